tlp_rx_hdr_parser: RTL and testbench
====================================

Name: tlp_rx_hdr_parser

Overview:
Receive-side counterpart of the TLP header assembly logic. Takes an inbound DW-serial TLP stream from the link layer. It captures the 3DW or 4DW header, decodes fmt/type/DW0 control bits and the requester ID (ARI or non-ARI), and forwards the payload DWs. It strips the optional ECRC digest and flags malformed or unsupported TLPs to the transaction-layer error logic.

Parameters:
MAX_PAYLOAD_DW, 1024, largest legal payload in DW; a larger decoded length is malformed
CNT_W, 16, width of the packet and error statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ari_enabled  in  1  requester ID decode mode
in_data  in  32  inbound TLP DW, header DW0 first
in_valid  in  1  in_data valid
in_sop  in  1  first DW of TLP
in_eop  in  1  last DW of TLP
in_ready  out  1  parser accepts DW this cycle
hdr_valid  out  1  decoded header fields valid
hdr_ready  in  1  consumer accepts header
hdr_fmt  out  3  DW0[31:29]
hdr_type  out  5  DW0[28:24]
hdr_tc  out  3  DW0[22:20]
hdr_th, hdr_td, hdr_ep  out  1 each  DW0[16], [15], [14]
hdr_attr  out  3  {DW0[18], DW0[13:12]}
hdr_len_dw  out  11  payload DW count; length field 0 -> 1024
hdr_is_4dw  out  1  fmt[0]
hdr_has_data  out  1  fmt[1]
req_bus  out  8  DW1[31:24]
req_dev  out  5  DW1[23:19] non-ARI; 0 in ARI
req_fnc  out  8  {5'b0,DW1[18:16]} non-ARI; DW1[23:16] in ARI
hdr_tag  out  8  DW1[15:8]
hdr_be  out  8  {last_be, first_be} = DW1[7:0]
hdr_addr  out  64  4DW: {DW2, DW3[31:2], 2'b00}; 3DW: {32'b0, DW2[31:2], 2'b00}
pl_data  out  32  payload DW
pl_valid  out  1  payload valid
pl_last  out  1  final payload DW
pl_ready  in  1  payload consumer ready
ecrc  out  32  captured digest, valid when hdr_td and the TLP completes
err_malformed  out  1  one-cycle pulse
err_unsupported  out  1  one-cycle pulse
pkt_count  out  CNT_W  TLPs completed without error, saturating
err_count  out  CNT_W  TLPs dropped or flagged, saturating

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counters 0, in_ready 0. in_ready rises the first cycle after reset deasserts.
- States: IDLE, HDR1, HDR2, HDR3, HOLD, PAYLOAD, DIGEST, DROP.
- IDLE: in_ready=1. DW accepted with in_sop captures DW0 -> HDR1. A DW without in_sop is discarded silently.
- DW0 check: fmt=3'b100 (prefix) or a reserved fmt/type pair -> err_unsupported pulse -> DROP (or IDLE if in_eop).
- HDR1 -> HDR2. HDR2 -> HDR3 if fmt[0], else header complete. HDR3 -> header complete.
- Header complete: hdr_valid=1 the next cycle, fields registered and stable while hdr_valid=1; state HOLD.
- HOLD: in_ready=0. On hdr_valid&&hdr_ready, go to PAYLOAD if has_data, DIGEST if td, else IDLE.
- PAYLOAD: pl_data=in_data, pl_valid=in_valid, in_ready=pl_ready (combinational pass-through, zero latency). A down-counter loaded with hdr_len_dw drives pl_last when count==1. At count==1 go to DIGEST if td, else IDLE.
- DIGEST: one DW captured into ecrc, not forwarded -> IDLE.
- Expected-last DW must carry in_eop, else err_malformed -> DROP.
- in_eop earlier than expected (including during header) -> err_malformed, pl_last forced on that DW if in PAYLOAD -> IDLE.
- in_sop in any non-IDLE state -> err_malformed; the current TLP is abandoned and the DW is treated as a new DW0.
- hdr_len_dw > MAX_PAYLOAD_DW, or has_data=0 with TD implying payload mismatch -> err_malformed before hdr_valid, no header emitted -> DROP.
- DROP: in_ready=1, discards until in_eop -> IDLE.
- Counters: pkt_count +1 on clean return to IDLE; err_count +1 per error pulse; both saturate at all-ones.
- Both error pulses in one cycle: both assert, err_count +1 only.

Decomposition:
- Shared package tlp_pkg: fmt constants (FMT_3DW_NODATA etc.), type codes (MRD, MWR, IORD, IOWR, CFG0, CFG1, MSG, CPL, CPLD, FETCHADD, SWAP, CAS), DW0 bit-position constants, state enum.
- One sub-module, tlp_rid_decode: combinational requester ID split driven by ari_enabled, shared with the transmit side.

Test Plan:
- 3DW MWr, fmt=010 type=00000 len=2 TD=0, 2 payload DWs, hdr_ready=1 -> hdr_valid 1 cycle, hdr_addr={32'b0,DW2&~3}, pl_last on DW 2, pkt_count=1.
- 4DW MRd, fmt=001 len=0, DW1=16'h1A2B, ari_enabled=0 -> hdr_len_dw=1024, req_bus=8'h1A, req_dev=5, req_fnc=3, no pl_valid.
- Same DW1 with ari_enabled=1 -> req_dev=0, req_fnc=8'h2B.
- MWr len=4 with in_eop on payload DW 2 -> err_malformed pulse, pl_last on DW 2, err_count=1, next TLP parses cleanly.
- TD=1 CplD len=1, hdr_ready held 0 for 5 cycles -> in_ready=0 throughout HOLD, then 1 payload DW forwarded, ecrc=digest DW.
- fmt=100 sop DW followed by 3 DWs and eop -> err_unsupported pulse, DWs dropped, rst pulsed mid-packet returns all outputs to 0.

Source files
------------

// File: rtl/tlp_pkg.sv
// Shared TLP definitions: fmt/type codes, DW0 field positions, receive FSM states.
package tlp_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
    localparam logic [2:0] FMT_PREFIX     = 3'b100;

    // Read/write pairs share a type code; fmt tells them apart.
    localparam logic [4:0] TYPE_MRD      = 5'b00000;
    localparam logic [4:0] TYPE_MWR      = 5'b00000;
    localparam logic [4:0] TYPE_IORD     = 5'b00010;
    localparam logic [4:0] TYPE_IOWR     = 5'b00010;
    localparam logic [4:0] TYPE_CFG0     = 5'b00100;
    localparam logic [4:0] TYPE_CFG1     = 5'b00101;
    localparam logic [4:0] TYPE_MSG      = 5'b10000; // low 3 bits carry routing
    localparam logic [4:0] TYPE_CPL      = 5'b01010;
    localparam logic [4:0] TYPE_CPLD     = 5'b01010;
    localparam logic [4:0] TYPE_FETCHADD = 5'b01100;
    localparam logic [4:0] TYPE_SWAP     = 5'b01101;
    localparam logic [4:0] TYPE_CAS      = 5'b01110;

    localparam int DW0_FMT_LSB  = 29;
    localparam int DW0_TYPE_LSB = 24;
    localparam int DW0_TC_LSB   = 20;
    localparam int DW0_ATTR2    = 18;
    localparam int DW0_TH       = 16;
    localparam int DW0_TD       = 15;
    localparam int DW0_EP       = 14;
    localparam int DW0_ATTR_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR1, ST_HDR2, ST_HDR3, ST_HOLD, ST_PAYLOAD, ST_DIGEST, ST_DROP
    } state_e;

    // Length field of 0 encodes the maximum of 1024 DW.
    function automatic logic [10:0] len_to_dw(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    // Prefixes and any fmt/type pair outside the supported set are rejected.
    function automatic logic is_unsupported(input logic [2:0] fmt, input logic [4:0] typ);
        logic ok;
        ok = 1'b0;
        if (typ == TYPE_MRD || typ == TYPE_MWR)
            ok = (fmt[2] == 1'b0);
        else if (typ == TYPE_IORD || typ == TYPE_IOWR || typ == TYPE_CFG0 ||
                 typ == TYPE_CFG1 || typ == TYPE_CPL  || typ == TYPE_CPLD)
            ok = (fmt == FMT_3DW_NODATA) || (fmt == FMT_3DW_DATA);
        else if (typ[4:3] == TYPE_MSG[4:3])
            ok = (fmt == FMT_4DW_NODATA) || (fmt == FMT_4DW_DATA);
        else if (typ == TYPE_FETCHADD || typ == TYPE_SWAP || typ == TYPE_CAS)
            ok = (fmt == FMT_3DW_DATA) || (fmt == FMT_4DW_DATA);
        return (fmt == FMT_PREFIX) || !ok;
    endfunction

endpackage

// File: rtl/tlp_rid_decode.sv
// Requester ID split into bus/device/function, ARI or legacy layout.
module tlp_rid_decode (
    input  logic        ari_enabled,
    input  logic [15:0] rid,
    output logic [7:0]  bus,
    output logic [4:0]  dev,
    output logic [7:0]  fnc
);

    // ARI folds the device number into an 8-bit function number.
    always_comb begin
        bus = rid[15:8];
        if (ari_enabled) begin
            dev = 5'd0;
            fnc = rid[7:0];
        end else begin
            dev = rid[7:3];
            fnc = {5'b0, rid[2:0]};
        end
    end

endmodule

// File: rtl/tlp_rx_hdr_parser.sv
// Inbound TLP header parser: captures 3DW/4DW header, forwards payload,
// strips ECRC, flags malformed/unsupported TLPs and keeps statistics.
module tlp_rx_hdr_parser
    import tlp_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ari_enabled,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic [2:0]       hdr_fmt,
    output logic [4:0]       hdr_type,
    output logic [2:0]       hdr_tc,
    output logic             hdr_th,
    output logic             hdr_td,
    output logic             hdr_ep,
    output logic [2:0]       hdr_attr,
    output logic [10:0]      hdr_len_dw,
    output logic             hdr_is_4dw,
    output logic             hdr_has_data,
    output logic [7:0]       req_bus,
    output logic [4:0]       req_dev,
    output logic [7:0]       req_fnc,
    output logic [7:0]       hdr_tag,
    output logic [7:0]       hdr_be,
    output logic [63:0]      hdr_addr,
    output logic [31:0]      pl_data,
    output logic             pl_valid,
    output logic             pl_last,
    input  logic             pl_ready,
    output logic [31:0]      ecrc,
    output logic             err_malformed,
    output logic             err_unsupported,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    state_e      state_q, state_d;
    logic        en_q;
    logic [31:0] dw0_q, dw1_q, dw2_q;
    logic [31:2] dw3_q;
    logic [10:0] cnt_q;
    logic        acc, hdr_end;
    logic        cap0, cap1, cap2, cap3, cap_ecrc, hdr_set, hdr_clr, ld_cnt, dec_cnt;
    logic        mal_d, uns_d, done_d;
    logic        q_has_data, q_is_4dw, q_td, in_unsup, in_len_bad;
    logic [7:0]  rid_bus, rid_fnc;
    logic [4:0]  rid_dev;
    logic        unused_bits;

    assign acc        = in_valid && in_ready;
    assign q_has_data = dw0_q[DW0_FMT_LSB+1];
    assign q_is_4dw   = dw0_q[DW0_FMT_LSB];
    assign q_td       = dw0_q[DW0_TD];
    assign in_unsup   = is_unsupported(in_data[DW0_FMT_LSB +: 3], in_data[DW0_TYPE_LSB +: 5]);
    assign in_len_bad = in_data[DW0_FMT_LSB+1] &&
                        (32'(len_to_dw(in_data[9:0])) > MAX_PAYLOAD_DW);
    assign unused_bits = ^{dw0_q[23], dw0_q[19], dw0_q[17], dw0_q[11:10]};

    tlp_rid_decode u_rid (
        .ari_enabled (ari_enabled),
        .rid         (dw1_q[31:16]),
        .bus         (rid_bus),
        .dev         (rid_dev),
        .fnc         (rid_fnc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus per-DW capture strobes and error/completion events.
    always_comb begin
        state_d = state_q;
        {cap0, cap1, cap2, cap3, cap_ecrc, hdr_set, hdr_clr, ld_cnt, dec_cnt} = '0;
        {mal_d, uns_d, done_d, hdr_end} = '0;
        if (acc && in_sop) begin
            // A start-of-packet always restarts parsing from this DW.
            mal_d = (state_q != ST_IDLE);
            cap0  = 1'b1;
            if (in_unsup) begin
                uns_d   = 1'b1;
                state_d = in_eop ? ST_IDLE : ST_DROP;
            end else if (in_eop) begin
                mal_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (in_len_bad) begin
                mal_d   = 1'b1;
                state_d = ST_DROP;
            end else begin
                state_d = ST_HDR1;
            end
        end else if (acc) begin
            case (state_q)
                ST_HDR1: begin
                    cap1 = 1'b1;
                    if (in_eop) begin mal_d = 1'b1; state_d = ST_IDLE; end
                    else state_d = ST_HDR2;
                end
                ST_HDR2: begin
                    cap2 = 1'b1;
                    if (!q_is_4dw) hdr_end = 1'b1;
                    else if (in_eop) begin mal_d = 1'b1; state_d = ST_IDLE; end
                    else state_d = ST_HDR3;
                end
                ST_HDR3: begin
                    cap3    = 1'b1;
                    hdr_end = 1'b1;
                end
                ST_PAYLOAD: begin
                    dec_cnt = 1'b1;
                    if (cnt_q == 11'd1) begin
                        if (q_td) begin
                            if (in_eop) begin mal_d = 1'b1; state_d = ST_IDLE; end
                            else state_d = ST_DIGEST;
                        end else if (in_eop) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            mal_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (in_eop) begin
                        mal_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DIGEST: begin
                    cap_ecrc = 1'b1;
                    if (in_eop) begin done_d = 1'b1; state_d = ST_IDLE; end
                    else begin mal_d = 1'b1; state_d = ST_DROP; end
                end
                ST_DROP: if (in_eop) state_d = ST_IDLE;
                default: ;
            endcase
        end else if (state_q == ST_HOLD && hdr_valid && hdr_ready) begin
            hdr_clr = 1'b1;
            if (q_has_data) begin
                ld_cnt  = 1'b1;
                state_d = ST_PAYLOAD;
            end else if (q_td) begin
                state_d = ST_DIGEST;
            end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
        // Last header DW: eop must land exactly where the header says the TLP ends.
        if (hdr_end) begin
            if (q_has_data || q_td) begin
                if (in_eop) begin mal_d = 1'b1; state_d = ST_IDLE; end
                else begin hdr_set = 1'b1; state_d = ST_HOLD; end
            end else if (in_eop) begin
                hdr_set = 1'b1;
                state_d = ST_HOLD;
            end else begin
                mal_d   = 1'b1;
                state_d = ST_DROP;
            end
        end
    end

    // Stream-side outputs: payload is a zero-latency pass-through.
    always_comb begin
        in_ready = 1'b0;
        pl_valid = 1'b0;
        pl_data  = '0;
        pl_last  = 1'b0;
        case (state_q)
            ST_HOLD: in_ready = 1'b0;
            ST_PAYLOAD: begin
                in_ready = pl_ready;
                pl_valid = in_valid && !in_sop;
                pl_data  = in_data;
                pl_last  = pl_valid && ((cnt_q == 11'd1) || in_eop);
            end
            default: in_ready = 1'b1;
        endcase
        in_ready = in_ready && en_q;
    end

    // Header fields, driven only while the header is being offered.
    always_comb begin
        {hdr_fmt, hdr_type, hdr_tc, hdr_th, hdr_td, hdr_ep, hdr_attr} = '0;
        {hdr_len_dw, hdr_is_4dw, hdr_has_data} = '0;
        {req_bus, req_dev, req_fnc, hdr_tag, hdr_be, hdr_addr} = '0;
        if (hdr_valid) begin
            hdr_fmt      = dw0_q[DW0_FMT_LSB +: 3];
            hdr_type     = dw0_q[DW0_TYPE_LSB +: 5];
            hdr_tc       = dw0_q[DW0_TC_LSB +: 3];
            hdr_th       = dw0_q[DW0_TH];
            hdr_td       = q_td;
            hdr_ep       = dw0_q[DW0_EP];
            hdr_attr     = {dw0_q[DW0_ATTR2], dw0_q[DW0_ATTR_LSB +: 2]};
            hdr_len_dw   = len_to_dw(dw0_q[9:0]);
            hdr_is_4dw   = q_is_4dw;
            hdr_has_data = q_has_data;
            req_bus      = rid_bus;
            req_dev      = rid_dev;
            req_fnc      = rid_fnc;
            hdr_tag      = dw1_q[15:8];
            hdr_be       = dw1_q[7:0];
            hdr_addr     = q_is_4dw ? {dw2_q, dw3_q, 2'b00} : {32'b0, dw2_q[31:2], 2'b00};
        end
    end

    // Header/digest capture, payload down-counter, error pulses, statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q            <= 1'b0;
            dw0_q           <= '0;
            dw1_q           <= '0;
            dw2_q           <= '0;
            dw3_q           <= '0;
            cnt_q           <= '0;
            hdr_valid       <= 1'b0;
            ecrc            <= '0;
            err_malformed   <= 1'b0;
            err_unsupported <= 1'b0;
            pkt_count       <= '0;
            err_count       <= '0;
        end else begin
            en_q <= 1'b1;
            if (cap0)     dw0_q <= in_data;
            if (cap1)     dw1_q <= in_data;
            if (cap2)     dw2_q <= in_data;
            if (cap3)     dw3_q <= in_data[31:2];
            if (cap_ecrc) ecrc  <= in_data;
            if (hdr_set)      hdr_valid <= 1'b1;
            else if (hdr_clr) hdr_valid <= 1'b0;
            if (ld_cnt)       cnt_q <= len_to_dw(dw0_q[9:0]);
            else if (dec_cnt) cnt_q <= cnt_q - 11'd1;
            err_malformed   <= mal_d;
            err_unsupported <= uns_d;
            if ((mal_d || uns_d) && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + 1'b1;
            if (done_d && (pkt_count != {CNT_W{1'b1}}))
                pkt_count <= pkt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlp_rx_hdr_parser.sv
// Directed bench for tlp_rx_hdr_parser.
module tb_tlp_rx_hdr_parser;

    logic        clk, rst, ari_enabled;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop, in_ready;
    logic        hdr_valid, hdr_ready;
    logic [2:0]  hdr_fmt, hdr_tc, hdr_attr;
    logic [4:0]  hdr_type, req_dev;
    logic        hdr_th, hdr_td, hdr_ep, hdr_is_4dw, hdr_has_data;
    logic [10:0] hdr_len_dw;
    logic [7:0]  req_bus, req_fnc, hdr_tag, hdr_be;
    logic [63:0] hdr_addr;
    logic [31:0] pl_data, ecrc;
    logic        pl_valid, pl_last, pl_ready;
    logic        err_malformed, err_unsupported;
    logic [15:0] pkt_count, err_count;

    tlp_rx_hdr_parser #(.MAX_PAYLOAD_DW(1024), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ari_enabled(ari_enabled),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_fmt(hdr_fmt), .hdr_type(hdr_type), .hdr_tc(hdr_tc),
        .hdr_th(hdr_th), .hdr_td(hdr_td), .hdr_ep(hdr_ep), .hdr_attr(hdr_attr),
        .hdr_len_dw(hdr_len_dw), .hdr_is_4dw(hdr_is_4dw), .hdr_has_data(hdr_has_data),
        .req_bus(req_bus), .req_dev(req_dev), .req_fnc(req_fnc),
        .hdr_tag(hdr_tag), .hdr_be(hdr_be), .hdr_addr(hdr_addr),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
        .ecrc(ecrc), .err_malformed(err_malformed), .err_unsupported(err_unsupported),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor sampled on the inactive edge.
    int          pl_n = 0, last_n = 0, last_pos = 0, mal_n = 0, uns_n = 0, hv_n = 0;
    logic [31:0] last_data = '0;
    logic        hv_prev = 1'b0;
    logic [10:0] h_len;
    logic [63:0] h_addr;
    logic [7:0]  h_bus, h_fnc, h_tag, h_be;
    logic [4:0]  h_dev, h_type;
    logic [2:0]  h_fmt;
    logic        h_td;

    always @(negedge clk) begin
        if (pl_valid && pl_ready) begin
            pl_n      <= pl_n + 1;
            last_data <= pl_data;
            if (pl_last) begin
                last_n   <= last_n + 1;
                last_pos <= pl_n + 1;
            end
        end
        if (err_malformed)   mal_n <= mal_n + 1;
        if (err_unsupported) uns_n <= uns_n + 1;
        if (hdr_valid) hv_n <= hv_n + 1;
        if (hdr_valid && !hv_prev) begin
            h_len <= hdr_len_dw; h_addr <= hdr_addr; h_bus <= req_bus; h_fnc <= req_fnc;
            h_dev <= req_dev; h_tag <= hdr_tag; h_be <= hdr_be; h_type <= hdr_type;
            h_fmt <= hdr_fmt; h_td <= hdr_td;
        end
        hv_prev <= hdr_valid;
    end

    // Offer one DW and hold it until accepted.
    task automatic send(input logic [31:0] d, input logic sop, input logic eop);
        int n;
        in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_pl, b_last, b_mal, b_uns, b_hv;

    task automatic snap();
        b_pl = pl_n; b_last = last_n; b_mal = mal_n; b_uns = uns_n; b_hv = hv_n;
    endtask

    initial begin
        rst = 1'b1; ari_enabled = 1'b0; hdr_ready = 1'b1; pl_ready = 1'b1;
        in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        #2 rst = 1'b0;
        idle(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b1;
        idle(1);
        chk("in_ready_up", in_ready, 1);

        // 3DW MWr, len 2
        snap();
        send(32'h4000_0002, 1, 0);
        send(32'h0100_05FF, 0, 0);
        send(32'h1234_5677, 0, 0);
        send(32'hA000_0001, 0, 0);
        send(32'hA000_0002, 0, 1);
        idle(3);
        chk("mwr_hv_cycles", hv_n - b_hv, 1);
        chk("mwr_addr", h_addr, 64'h0000_0000_1234_5674);
        chk("mwr_len", h_len, 2);
        chk("mwr_fmt", h_fmt, 3'b010);
        chk("mwr_be", h_be, 8'hFF);
        chk("mwr_pl_n", pl_n - b_pl, 2);
        chk("mwr_last_pos", last_pos - b_pl, 2);
        chk("mwr_last_data", last_data, 32'hA000_0002);
        chk("mwr_pkt", pkt_count, 1);
        chk("mwr_err", err_count, 0);

        // 4DW MRd, len 0 -> 1024, non-ARI requester
        snap();
        send(32'h2000_0000, 1, 0);
        send(32'h1A2B_0700, 0, 0);
        send(32'h0000_0001, 0, 0);
        send(32'h8000_000C, 0, 1);
        idle(3);
        chk("mrd_len", h_len, 1024);
        chk("mrd_bus", h_bus, 8'h1A);
        chk("mrd_dev", h_dev, 5);
        chk("mrd_fnc", h_fnc, 3);
        chk("mrd_tag", h_tag, 8'h07);
        chk("mrd_addr", h_addr, 64'h0000_0001_8000_000C);
        chk("mrd_no_pl", pl_n - b_pl, 0);
        chk("mrd_pkt", pkt_count, 2);

        // Same request, ARI decode
        ari_enabled = 1'b1;
        send(32'h2000_0000, 1, 0);
        send(32'h1A2B_0700, 0, 0);
        send(32'h0000_0001, 0, 0);
        send(32'h8000_000C, 0, 1);
        idle(3);
        chk("ari_dev", h_dev, 0);
        chk("ari_fnc", h_fnc, 8'h2B);
        chk("ari_bus", h_bus, 8'h1A);
        ari_enabled = 1'b0;

        // MWr len 4 ending early on payload DW 2, then a clean TLP
        snap();
        send(32'h4000_0004, 1, 0);
        send(32'h0100_0100, 0, 0);
        send(32'h0000_0040, 0, 0);
        send(32'hB000_0001, 0, 0);
        send(32'hB000_0002, 0, 1);
        idle(3);
        chk("early_mal", mal_n - b_mal, 1);
        chk("early_last_pos", last_pos - b_pl, 2);
        chk("early_err", err_count, 1);
        chk("early_pkt", pkt_count, 3);
        send(32'h4000_0001, 1, 0);
        send(32'h0100_0200, 0, 0);
        send(32'h0000_0080, 0, 0);
        send(32'hB000_0003, 0, 1);
        idle(3);
        chk("recover_pkt", pkt_count, 4);
        chk("recover_err", err_count, 1);

        // CplD with digest, consumer stalls the header
        snap();
        hdr_ready = 1'b0;
        send(32'h4A00_8001, 1, 0);
        send(32'h0011_0004, 0, 0);
        send(32'h0022_0300, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_hdr_valid", hdr_valid, 1);
        end
        hdr_ready = 1'b1;
        @(posedge clk); #1;
        send(32'hDEAD_BEEF, 0, 0);
        send(32'hC0FF_EE11, 0, 1);
        idle(3);
        chk("cpld_type", h_type, 5'b01010);
        chk("cpld_td", h_td, 1);
        chk("cpld_pl_n", pl_n - b_pl, 1);
        chk("cpld_last", last_n - b_last, 1);
        chk("cpld_data", last_data, 32'hDEAD_BEEF);
        chk("cpld_ecrc", ecrc, 32'hC0FF_EE11);
        chk("cpld_pkt", pkt_count, 5);

        // TLP prefix -> unsupported, rest dropped
        snap();
        send(32'h8000_0000, 1, 0);
        send(32'h0000_0001, 0, 0);
        send(32'h0000_0002, 0, 0);
        send(32'h0000_0003, 0, 1);
        idle(3);
        chk("pfx_uns", uns_n - b_uns, 1);
        chk("pfx_mal", mal_n - b_mal, 0);
        chk("pfx_no_hdr", hv_n - b_hv, 0);
        chk("pfx_err", err_count, 2);
        chk("pfx_pkt", pkt_count, 5);

        // sop inside a header restarts parsing
        snap();
        send(32'h4000_0002, 1, 0);
        send(32'h0100_0000, 0, 0);
        send(32'h0000_0001, 1, 0);
        send(32'h00AA_0100, 0, 0);
        send(32'h0000_1000, 0, 1);
        idle(3);
        chk("resop_mal", mal_n - b_mal, 1);
        chk("resop_fmt", h_fmt, 0);
        chk("resop_addr", h_addr, 64'h1000);
        chk("resop_pkt", pkt_count, 6);
        chk("resop_err", err_count, 3);

        // Both errors at once count once
        snap();
        send(32'h4000_0002, 1, 0);
        send(32'h8000_0000, 1, 1);
        idle(3);
        chk("both_mal", mal_n - b_mal, 1);
        chk("both_uns", uns_n - b_uns, 1);
        chk("both_err", err_count, 4);

        // Reset while a header is held
        hdr_ready = 1'b0;
        send(32'h4000_0001, 1, 0);
        send(32'h0100_0000, 0, 0);
        send(32'h0000_2000, 0, 0);
        idle(2);
        chk("pre_rst_hv", hdr_valid, 1);
        rst = 1'b0;
        #1;
        chk("rst2_hv", hdr_valid, 0);
        chk("rst2_len", hdr_len_dw, 0);
        chk("rst2_addr", hdr_addr, 0);
        chk("rst2_in_ready", in_ready, 0);
        chk("rst2_pkt", pkt_count, 0);
        chk("rst2_err", err_count, 0);
        chk("rst2_ecrc", ecrc, 0);
        @(posedge clk); #1;
        rst = 1'b1; hdr_ready = 1'b1;
        idle(2);
        send(32'h0000_0001, 1, 0);
        send(32'h0000_0000, 0, 0);
        send(32'h0000_0100, 0, 1);
        idle(3);
        chk("post_rst_pkt", pkt_count, 1);
        chk("post_rst_err", err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
